cons_unit: RTL

CONS_UNIT -- requirements
Module: cons_unit

---
 rtl/cons_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/cons_unit.sv
// ============================================================================
// Module      : cons_unit
// Description : Lisp-style cons-cell allocator in front of a word-addressed
//               memory. CONS writes car/cdr into the next free two-word cell
//               and returns its pointer; CAR/CDR read one word of a cell.
//               Every accepted op produces a one-cycle result strobe in the
//               third cycle after the acceptance cycle.
// Ports       : clk, rst                 - clock, sync active-high reset
//               boot_done                - memory boot-complete pulse
//               op_valid/op_ready        - request handshake
//               op_code/op_car/op_cdr/op_ptr - request fields
//               result_valid/data/err    - result strobe and payload
//               mem_write_enable/mem_addr/mem_write_data/mem_read_data
//                                        - memory-controller port
// Options     : define CONS_UNIT_PTR_CHECK_EN to reject CAR/CDR pointers that
//               are odd, below the heap base or not yet allocated.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cons_unit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int HEAP_BASE  = 0,
  parameter int HEAP_LIMIT = 2**ADDR_WIDTH - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  boot_done,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [1:0]            op_code,
  input  logic [DATA_WIDTH-1:0] op_car,
  input  logic [DATA_WIDTH-1:0] op_cdr,
  input  logic [ADDR_WIDTH-1:0] op_ptr,
  output logic                  result_valid,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic                  result_err,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  // free_ptr carries one extra bit so "heap full" (HEAP_LIMIT+2) is still
  // distinguishable when HEAP_LIMIT sits at the top of the address space.
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] C_HEAP_BASE  = PW'(HEAP_BASE);
  localparam logic [PW-1:0] C_HEAP_LIMIT = PW'(HEAP_LIMIT);

  localparam logic [1:0] C_OP_CONS = 2'd0;
  localparam logic [1:0] C_OP_CAR  = 2'd1;
  localparam logic [1:0] C_OP_CDR  = 2'd2;

  typedef enum logic [2:0] {
    WAIT_BOOT = 3'd0,
    IDLE      = 3'd1,
    WR_CAR    = 3'd2,
    WR_CDR    = 3'd3,
    RD_ADDR   = 3'd4,
    RD_DATA   = 3'd5,
    RESP      = 3'd6
  } state_t;

  state_t                state_q;
  logic [PW-1:0]         free_ptr_q;
  logic [DATA_WIDTH-1:0] cdr_q;
  logic                  err_q;   // op resolved to an error at acceptance
  logic                  ptr_bad_d;

`ifdef CONS_UNIT_PTR_CHECK_EN
  // Borrow out of (ptr - base) flags a pointer below the heap base.
  logic [PW:0] base_diff_d;
  assign base_diff_d = {2'b00, op_ptr} - {1'b0, C_HEAP_BASE};
  assign ptr_bad_d   = op_ptr[0] | base_diff_d[PW] | ({1'b0, op_ptr} >= free_ptr_q);
`else
  assign ptr_bad_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= WAIT_BOOT;
      free_ptr_q       <= C_HEAP_BASE;
      cdr_q            <= '0;
      err_q            <= 1'b0;
      op_ready         <= 1'b0;
      result_valid     <= 1'b0;
      result_data      <= '0;
      result_err       <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_addr         <= '0;
      mem_write_data   <= '0;
    end else begin
      result_valid <= 1'b0;
      case (state_q)
        WAIT_BOOT: begin
          if (boot_done) begin
            state_q  <= IDLE;
            op_ready <= 1'b1;
          end
        end

        IDLE: begin
          if (op_valid && op_ready) begin
            op_ready <= 1'b0;
            cdr_q    <= op_cdr;
            // Error paths reuse RD_ADDR/RD_DATA purely as delay slots with
            // mem_addr left at 0, so every op shares one latency.
            state_q  <= RD_ADDR;
            err_q    <= 1'b1;
            case (op_code)
              C_OP_CONS: begin
                if (free_ptr_q <= C_HEAP_LIMIT) begin
                  state_q          <= WR_CAR;
                  err_q            <= 1'b0;
                  mem_write_enable <= 1'b1;
                  mem_addr         <= free_ptr_q[ADDR_WIDTH-1:0];
                  mem_write_data   <= op_car;
                end
              end
              C_OP_CAR, C_OP_CDR: begin
                if (!ptr_bad_d) begin
                  err_q    <= 1'b0;
                  mem_addr <= (op_code == C_OP_CDR) ? op_ptr + ADDR_WIDTH'(1) : op_ptr;
                end
              end
              default: ;
            endcase
          end
        end

        WR_CAR: begin
          state_q        <= WR_CDR;
          mem_addr       <= mem_addr + ADDR_WIDTH'(1);
          mem_write_data <= cdr_q;
        end

        WR_CDR: begin
          state_q          <= RESP;
          mem_write_enable <= 1'b0;
          mem_addr         <= '0;
          mem_write_data   <= '0;
          result_valid     <= 1'b1;
          result_err       <= 1'b0;
          result_data      <= DATA_WIDTH'(free_ptr_q[ADDR_WIDTH-1:0]);
          free_ptr_q       <= free_ptr_q + PW'(2);
        end

        RD_ADDR: begin
          state_q <= RD_DATA;
        end

        RD_DATA: begin
          // Read data for the address issued in RD_ADDR is valid now.
          state_q      <= RESP;
          mem_addr     <= '0;
          result_valid <= 1'b1;
          result_err   <= err_q;
          result_data  <= err_q ? '0 : mem_read_data;
          err_q        <= 1'b0;
        end

        RESP: begin
          state_q  <= IDLE;
          op_ready <= 1'b1;
        end

        default: begin
          state_q  <= WAIT_BOOT;
          op_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
